// File: rtl/cordic_pkg.sv
// Shared constants for the CORDIC cosine engine: word format, gain preload and arctangent table.
package cordic_pkg;

  localparam int W     = 21;
  localparam int FRAC  = 20;
  localparam int ITERS = 16;

  // Preloading x with 1/gain means the rotation chain ends on cos(z) with no final scaling
  localparam logic [W-1:0] K_INIT = 21'h09B74E;

  localparam logic [W-1:0] ATAN_LUT [16] = '{
    21'h0C90FE, 21'h076B1A, 21'h03EB6F, 21'h01FD5C,
    21'h00FFAB, 21'h007FF5, 21'h003FFF, 21'h002000,
    21'h001000, 21'h000800, 21'h000400, 21'h000200,
    21'h000100, 21'h000080, 21'h000040, 21'h000020
  };

endpackage

// File: rtl/cordic_cos_pipe_stage.sv
// One combinational rotation-mode CORDIC micro-rotation; the sign of z picks the direction.
module cordic_stage
  import cordic_pkg::*;
(
  input  logic signed [W-1:0] x_in,
  input  logic signed [W-1:0] y_in,
  input  logic signed [W-1:0] z_in,
  input  logic        [4:0]   shift,
  input  logic        [W-1:0] atan,
  output logic signed [W-1:0] x_out,
  output logic signed [W-1:0] y_out,
  output logic signed [W-1:0] z_out
);

  logic signed [W-1:0] x_sh;
  logic signed [W-1:0] y_sh;

  // Rotate toward z=0; arithmetic shifts truncate and sums wrap at W bits
  always_comb begin
    x_sh = x_in >>> shift;
    y_sh = y_in >>> shift;
    if (!z_in[W-1]) begin
      x_out = x_in - y_sh;
      y_out = y_in + x_sh;
      z_out = z_in - $signed(atan);
    end else begin
      x_out = x_in + y_sh;
      y_out = y_in - x_sh;
      z_out = z_in + $signed(atan);
    end
  end

endmodule

// File: rtl/cordic_cos_pipe.sv
// Iterative CORDIC cosine: float angle in, float cosine out, UNROLLS rotations per enabled clock.
module cordic_cos_pipe
  import cordic_pkg::*;
#(
  parameter int UNROLLS = 4
) (
  input  logic        clock,
  input  logic        aclr_n,
  input  logic        clk_en,
  input  logic        start,
  input  logic [31:0] dataa,
  output logic [31:0] result,
  output logic        done
);

  logic        [4:0]   idx_q, idx_d;
  logic signed [W-1:0] x_q, x_d;
  logic signed [W-1:0] y_q, y_d;
  logic signed [W-1:0] z_q, z_d;

  logic signed [W-1:0] x_chain [UNROLLS+1];
  logic signed [W-1:0] y_chain [UNROLLS+1];
  logic signed [W-1:0] z_chain [UNROLLS+1];

  logic [7:0]   a_exp;
  logic [7:0]   a_shift;
  logic [23:0]  a_sig;
  logic [W-1:0] z_load;

  logic [W-1:0] x_u;
  logic [4:0]   msb_pos;
  logic [5:0]   norm_shift;
  logic [23:0]  mant_wide;
  logic [7:0]   r_exp;

  assign x_chain[0] = x_q;
  assign y_chain[0] = y_q;
  assign z_chain[0] = z_q;

  for (genvar k = 0; k < UNROLLS; k++) begin : g_stage
    logic [4:0] shift_k;
    assign shift_k = idx_q + 5'(k);
    cordic_stage u_stage (
      .x_in  (x_chain[k]),
      .y_in  (y_chain[k]),
      .z_in  (z_chain[k]),
      .shift (shift_k),
      .atan  (ATAN_LUT[shift_k[3:0]]),
      .x_out (x_chain[k+1]),
      .y_out (y_chain[k+1]),
      .z_out (z_chain[k+1])
    );
  end

  // Float magnitude to Q1.20: tiny angles flush to zero, >= 1.0 saturates just below 1.0
  always_comb begin
    a_exp   = dataa[30:23];
    a_sig   = {1'b1, dataa[22:0]};
    a_shift = 8'd130 - a_exp;
    z_load  = '0;
    if (a_exp >= 8'd127) begin
      z_load = 21'h0FFFFF;
    end else if (a_exp >= 8'd107) begin
      z_load = W'(a_sig >> a_shift);
    end
  end

  // Start wins over iteration; otherwise advance UNROLLS rotations until idx reaches ITERS
  always_comb begin
    idx_d = idx_q;
    x_d   = x_q;
    y_d   = y_q;
    z_d   = z_q;
    if (clk_en) begin
      if (start) begin
        idx_d = '0;
        x_d   = K_INIT;
        y_d   = '0;
        z_d   = z_load;
      end else if (idx_q < 5'(ITERS)) begin
        idx_d = idx_q + 5'(UNROLLS);
        x_d   = x_chain[UNROLLS];
        y_d   = y_chain[UNROLLS];
        z_d   = z_chain[UNROLLS];
      end
    end
  end

  // State registers; reset parks the engine in the finished state with zero output
  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) begin
      idx_q <= 5'(ITERS);
      x_q   <= '0;
      y_q   <= '0;
      z_q   <= '0;
    end else begin
      idx_q <= idx_d;
      x_q   <= x_d;
      y_q   <= y_d;
      z_q   <= z_d;
    end
  end

  // Exact unsigned Q1.20 to float: normalise on the leading one, zero stays +0.0
  always_comb begin
    x_u     = x_q;
    msb_pos = '0;
    for (int i = 0; i < W; i++) begin
      if (x_u[i]) msb_pos = 5'(i);
    end
    norm_shift = 6'd23 - {1'b0, msb_pos};
    mant_wide  = 24'(x_u) << norm_shift;
    r_exp      = 8'd107 + {3'b0, msb_pos};
    if (x_u == '0) begin
      result = 32'h0000_0000;
    end else begin
      result = {1'b0, r_exp, mant_wide[22:0]};
    end
  end

  assign done = (idx_q == 5'(ITERS));

endmodule

// File: tb/tb_cordic_cos_pipe.sv
// Self-checking bench for cordic_cos_pipe: arithmetic reference model plus directed scenarios.
module tb_cordic_cos_pipe;

  logic        clock;
  logic        aclr_n;
  logic        clk_en;
  logic        start;
  logic [31:0] dataa;
  logic [31:0] result;
  logic        done;

  int n_checks = 0;
  int n_fail   = 0;
  bit check_en = 0;

  int          m_remaining;
  logic [31:0] m_result;

  cordic_cos_pipe dut (
    .clock  (clock),
    .aclr_n (aclr_n),
    .clk_en (clk_en),
    .start  (start),
    .dataa  (dataa),
    .result (result),
    .done   (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference arctangent values in Q1.20
  int atan_tab [16] = '{
    'h0C90FE, 'h076B1A, 'h03EB6F, 'h01FD5C, 'h00FFAB, 'h007FF5, 'h003FFF, 'h002000,
    'h001000, 'h000800, 'h000400, 'h000200, 'h000100, 'h000080, 'h000040, 'h000020
  };

  function automatic int wrap21(input int v);
    int t;
    t = v & 'h1FFFFF;
    if (t >= 'h100000) t = t - 'h200000;
    return t;
  endfunction

  function automatic int model_f2x(input logic [31:0] a);
    int e;
    int sig;
    e = int'(a[30:23]);
    if (e < 107) return 0;
    if (e >= 127) return 'h0FFFFF;
    sig = int'({1'b1, a[22:0]});
    return sig / (1 << (130 - e));
  endfunction

  function automatic logic [31:0] model_cos(input logic [31:0] a);
    int x, y, z, nx, ny, nz, xu, p;
    logic [31:0] ex, mt;
    x = 'h09B74E; y = 0; z = model_f2x(a);
    for (int i = 0; i < 16; i++) begin
      if (z >= 0) begin
        nx = x - (y >>> i); ny = y + (x >>> i); nz = z - atan_tab[i];
      end else begin
        nx = x + (y >>> i); ny = y - (x >>> i); nz = z + atan_tab[i];
      end
      x = wrap21(nx); y = wrap21(ny); z = wrap21(nz);
    end
    xu = x & 'h1FFFFF;
    if (xu == 0) return 32'h0;
    p = 0;
    for (int i = 0; i < 21; i++) if ((xu >> i) & 1) p = i;
    ex = 32'(107 + p);
    mt = 32'((xu << (23 - p)) & 'h7FFFFF);
    return {1'b0, ex[7:0], mt[22:0]};
  endfunction

  function automatic real float_to_real(input logic [31:0] f);
    real v;
    int  e;
    e = int'(f[30:23]);
    if (e == 0) return 0.0;
    v = 1.0 + real'(f[22:0]) / 8388608.0;
    for (int i = 0; i < 127 - e; i++) v = v / 2.0;
    for (int i = 0; i < e - 127; i++) v = v * 2.0;
    return f[31] ? -v : v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic checkClose(input string name, input real actual, input real expected, input real tol);
    real d;
    n_checks++;
    d = actual - expected;
    if (d < 0.0) d = -d;
    if (d >= tol) begin
      n_fail++;
      $display("[TB] FAIL %s: got %f, expected %f (tol %f)", name, actual, expected, tol);
    end
  endtask

  // Cycle-level model: a start arms a four-edge countdown, enabled edges count it down
  always @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) begin
      m_remaining <= 0;
      m_result    <= 32'h0;
    end else if (clk_en) begin
      if (start) begin
        m_remaining <= 4;
        m_result    <= model_cos(dataa);
      end else if (m_remaining > 0) begin
        m_remaining <= m_remaining - 1;
      end
    end
  end

  // Compare DUT against the model on every falling edge
  always @(negedge clock) begin
    if (check_en && aclr_n) begin
      checkOutput("done", 32'(done), 32'(m_remaining == 0));
      if (m_remaining == 0) checkOutput("result", result, m_result);
    end
  end

  // Issue one start pulse and confirm the loaded angle
  task automatic applyStimulus(input logic [31:0] a);
    @(negedge clock);
    dataa  = a;
    start  = 1'b1;
    clk_en = 1'b1;
    @(posedge clock);
    #1;
    checkOutput("z_load", 32'(dut.z_q & 21'h1FFFFF), 32'(model_f2x(a)));
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic waitDone(input string name, output int edges);
    edges = 0;
    while (!done && edges < 40) begin
      @(posedge clock);
      #1;
      edges++;
    end
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL %s: done never rose, got 0, expected 1", name);
    end
  endtask

  logic [31:0] r_half, r_zero, held_res, held_x;
  int edges;

  initial begin
    aclr_n = 1'b0;
    clk_en = 1'b0;
    start  = 1'b0;
    dataa  = 32'h0;
    #12;
    checkOutput("reset_done", 32'(done), 32'h1);
    checkOutput("reset_result", result, 32'h0);
    @(negedge clock);
    aclr_n = 1'b1;
    check_en = 1;

    // Pin the reference model with hand-derived values
    checkOutput("model_f2x_one", 32'(model_f2x(32'h3F800000)), 32'h000FFFFF);
    checkOutput("model_f2x_half", 32'(model_f2x(32'h3F000000)), 32'h00080000);
    checkOutput("model_f2x_tiny", 32'(model_f2x(32'h33800000)), 32'h0);
    checkOutput("model_f2x_2m20", 32'(model_f2x(32'h35800000)), 32'h1);
    checkClose("model_cos_half", float_to_real(model_cos(32'h3F000000)), 0.8775825618903728, 0.00006103515625);
    checkClose("model_cos_one", float_to_real(model_cos(32'h3F800000)), 0.5403023058681398, 0.00006103515625);

    // Latency: done low for three edges, high after the fourth
    applyStimulus(32'h3F000000);
    for (int k = 1; k <= 4; k++) begin
      @(posedge clock);
      #1;
      checkOutput($sformatf("latency_edge%0d", k), 32'(done), 32'(k == 4));
    end
    r_half = result;
    checkClose("cos_half", float_to_real(result), 0.8775825618903728, 0.00006103515625);

    // Zero and negative zero
    applyStimulus(32'h00000000);
    waitDone("zero", edges);
    r_zero = result;
    checkClose("cos_zero", float_to_real(result), 1.0, 0.00006103515625);
    applyStimulus(32'h80000000);
    waitDone("negzero", edges);
    checkOutput("negzero_same", result, r_zero);

    // Even symmetry and saturation
    applyStimulus(32'hBF000000);
    waitDone("neghalf", edges);
    checkOutput("neghalf_same", result, r_half);
    applyStimulus(32'h3F800000);
    checkOutput("sat_z", 32'(dut.z_q & 21'h1FFFFF), 32'h000FFFFF);
    waitDone("one", edges);
    checkClose("cos_one", float_to_real(result), 0.5403023058681398, 0.00006103515625);

    // Tiny angle flushes to zero
    applyStimulus(32'h33800000);
    waitDone("tiny", edges);
    checkClose("cos_tiny", float_to_real(result), 1.0, 0.00006103515625);

    // Clock enable stall of three cycles mid-run
    applyStimulus(32'h3E800000);
    @(posedge clock);
    @(negedge clock);
    clk_en = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    clk_en = 1'b1;
    #0;
    edges = 4;
    while (!done && edges < 40) begin
      @(posedge clock);
      #1;
      edges++;
    end
    checkOutput("stall_latency", 32'(edges), 32'd7);

    // Restart while busy
    applyStimulus(32'h3F000000);
    repeat (2) @(posedge clock);
    applyStimulus(32'h3F400000);
    waitDone("restart", edges);
    checkOutput("restart_latency", 32'(edges), 32'd4);
    checkOutput("restart_result", result, model_cos(32'h3F400000));

    // Frozen after done
    held_res = result;
    held_x   = 32'(dut.x_q & 21'h1FFFFF);
    for (int k = 0; k < 10; k++) begin
      @(posedge clock);
      #1;
      checkOutput("hold_result", result, held_res);
      checkOutput("hold_idx", 32'(dut.idx_q), 32'd16);
      checkOutput("hold_x", 32'(dut.x_q & 21'h1FFFFF), held_x);
    end

    // Asynchronous reset in the middle of an operation
    applyStimulus(32'h3F000000);
    @(posedge clock);
    #2;
    aclr_n = 1'b0;
    #1;
    checkOutput("async_done", 32'(done), 32'h1);
    checkOutput("async_result", result, 32'h0);
    @(negedge clock);
    aclr_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clock);
      #1;
      checkOutput("post_reset_done", 32'(done), 32'h1);
      checkOutput("post_reset_result", result, 32'h0);
    end

    @(negedge clock);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
